// File: rtl/phase_timer_pkg.sv
// Shared types and helpers for the per-phase interval timer.
package phase_timer_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    // Index width for n items; never below 1 so a 1-bit select always exists.
    function automatic int clog2_min1(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

    // Add two values and clamp the result to the largest width-bit value.
    function automatic logic [31:0] sat_add(input logic [31:0] a, input logic [31:0] b, input int width);
        logic [32:0] sum;
        logic [32:0] max_val;
        sum     = {1'b0, a} + {1'b0, b};
        max_val = (33'd1 << width) - 33'd1;
        return (sum > max_val) ? max_val[31:0] : sum[31:0];
    endfunction

endpackage

// File: rtl/phase_timer_delay_mux.sv
// Picks the delay slice for a phase index; indices past the last phase fall back to phase 0.
module phase_delay_mux
    import phase_timer_pkg::*;
#(
    parameter int NUM_PHASES = 4,
    parameter int CNT_W      = 4,
    parameter int PW         = 2
) (
    input  logic [PW-1:0]               sel,
    input  logic [NUM_PHASES*CNT_W-1:0] delays,
    output logic [PW-1:0]               eff_phase,
    output logic [CNT_W-1:0]            delay
);

    logic [CNT_W-1:0] slices [NUM_PHASES];

    generate
        for (genvar gi = 0; gi < NUM_PHASES; gi++) begin : g_slice
            assign slices[gi] = delays[gi*CNT_W +: CNT_W];
        end
    endgenerate

    // Default to phase 0; only an in-range index overrides it.
    always_comb begin
        eff_phase = '0;
        delay     = slices[0];
        for (int i = 1; i < NUM_PHASES; i++) begin
            if (sel == PW'(i)) begin
                eff_phase = sel;
                delay     = slices[i];
            end
        end
    end

endmodule

// File: rtl/phase_timer.sv
// Per-phase interval timer: times the FSM's current phase and pulses expire when it elapses.
// Optional green-extension support is compiled in with the PHASE_TIMER_EXTEND_EN macro.
module phase_timer
    import phase_timer_pkg::*;
#(
    parameter int NUM_PHASES  = 4,
    parameter int CNT_W       = 4,
    parameter int AUTO_RELOAD = 0,
    parameter int EXT_STEP    = 2,
    parameter int MAX_EXT     = 3
) (
    input  logic                                 clk,
    input  logic                                 reset,
    input  logic                                 enable,
    input  logic [clog2_min1(NUM_PHASES)-1:0]    phase,
    input  logic [NUM_PHASES*CNT_W-1:0]          delays,
    input  logic                                 ext_req,
    output logic [CNT_W-1:0]                     count,
    output logic [CNT_W-1:0]                     cur_delay,
    output logic [NUM_PHASES-1:0]                phase_onehot,
    output logic                                 expire,
    output logic                                 busy
);

    localparam int PW = clog2_min1(NUM_PHASES);

    state_t                state_reg, state_next;
    logic [CNT_W-1:0]      count_reg, count_next;
    logic [CNT_W-1:0]      cur_delay_reg, cur_delay_next;
    logic [PW-1:0]         phase_reg, phase_next;
    logic [NUM_PHASES-1:0] onehot_reg, onehot_next;
    logic                  expire_reg, expire_next;
    logic                  busy_reg, busy_next;

    logic [PW-1:0]    eff_phase;
    logic [CNT_W-1:0] sel_delay;
    logic             phase_change;
    logic             at_limit;
    logic             reload_due;

    phase_delay_mux #(
        .NUM_PHASES (NUM_PHASES),
        .CNT_W      (CNT_W),
        .PW         (PW)
    ) u_mux (
        .sel       (phase),
        .delays    (delays),
        .eff_phase (eff_phase),
        .delay     (sel_delay)
    );

    assign phase_change = (eff_phase != phase_reg);
    assign at_limit     = (count_reg == cur_delay_reg);
    // In auto-reload mode the edge after an expiry pulse restarts the phase,
    // which keeps expire a true one-cycle pulse even for a zero delay.
    assign reload_due   = (AUTO_RELOAD != 0) && expire_reg;

`ifdef PHASE_TIMER_EXTEND_EN
    localparam int EW = clog2_min1(MAX_EXT + 1);
    localparam logic [EW-1:0] MAX_EXT_L = EW'(MAX_EXT);

    logic [EW-1:0] ext_cnt_reg, ext_cnt_next;
    logic [31:0]   ext_sum;

    assign ext_sum = sat_add({{(32-CNT_W){1'b0}}, cur_delay_reg}, 32'(EXT_STEP), CNT_W);

    // Extension counter register, cleared on every load.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) ext_cnt_reg <= '0;
        else        ext_cnt_reg <= ext_cnt_next;
    end
`else
    logic unused_ext;
    assign unused_ext = ext_req | (EXT_STEP == 0) | (MAX_EXT == 0);
`endif

    // State and registered outputs.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_reg     <= IDLE;
            count_reg     <= '0;
            cur_delay_reg <= '0;
            phase_reg     <= '0;
            onehot_reg    <= '0;
            expire_reg    <= 1'b0;
            busy_reg      <= 1'b0;
        end else begin
            state_reg     <= state_next;
            count_reg     <= count_next;
            cur_delay_reg <= cur_delay_next;
            phase_reg     <= phase_next;
            onehot_reg    <= onehot_next;
            expire_reg    <= expire_next;
            busy_reg      <= busy_next;
        end
    end

    // Next-state decision; enable low dominates, then phase change, then expiry.
    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE: if (enable) state_next = RUN;
            RUN: begin
                if (!enable)
                    state_next = IDLE;
                else if (!phase_change && !reload_due && at_limit && (AUTO_RELOAD == 0))
                    state_next = DONE;
            end
            DONE: begin
                if (!enable)          state_next = IDLE;
                else if (phase_change) state_next = RUN;
            end
            default: state_next = IDLE;
        endcase
    end

    // Datapath and output next values.
    always_comb begin
        logic load;
        load           = 1'b0;
        count_next     = count_reg;
        cur_delay_next = cur_delay_reg;
        phase_next     = phase_reg;
        expire_next    = 1'b0;
`ifdef PHASE_TIMER_EXTEND_EN
        ext_cnt_next   = ext_cnt_reg;
`endif
        if (!enable) begin
            count_next     = '0;
            cur_delay_next = '0;
            phase_next     = '0;
`ifdef PHASE_TIMER_EXTEND_EN
            ext_cnt_next   = '0;
`endif
        end else begin
            case (state_reg)
                IDLE: load = 1'b1;
                RUN: begin
                    if (phase_change || reload_due) begin
                        load = 1'b1;
                    end else if (at_limit) begin
                        expire_next = 1'b1;
                    end else begin
                        count_next = count_reg + 1'b1;
`ifdef PHASE_TIMER_EXTEND_EN
                        if (ext_req && (ext_cnt_reg < MAX_EXT_L)) begin
                            cur_delay_next = ext_sum[CNT_W-1:0];
                            ext_cnt_next   = ext_cnt_reg + 1'b1;
                        end
`endif
                    end
                end
                DONE: if (phase_change) load = 1'b1;
                default: load = 1'b0;
            endcase
        end

        if (load) begin
            phase_next     = eff_phase;
            cur_delay_next = sel_delay;
            count_next     = '0;
`ifdef PHASE_TIMER_EXTEND_EN
            ext_cnt_next   = '0;
`endif
        end

        onehot_next = '0;
        if (state_next != IDLE) onehot_next[phase_next] = 1'b1;
        busy_next = (state_next == RUN);
    end

    assign count        = count_reg;
    assign cur_delay    = cur_delay_reg;
    assign phase_onehot = onehot_reg;
    assign expire       = expire_reg;
    assign busy         = busy_reg;

endmodule

// File: doc/phase_timer.md
Name: phase_timer

Overview:
Parametrised per-phase interval timer for the traffic light controller, generalising the fixed 4-phase, 4-bit timer.
- Holds NUM_PHASES programmable delays of CNT_W bits each.
- Times the phase currently selected by the FSM and issues a one-cycle expire pulse when that phase's interval elapses.
- Sits between the light FSM (which drives phase and consumes expire) and the delay configuration registers.
- Adds one-shot/auto-reload modes, restart on phase change, and saturating green-extension requests.

Parameters:
- NUM_PHASES, 4, number of phases/delays (>=2)
- CNT_W, 4, width of count and delay values
- AUTO_RELOAD, 0, 0 = hold in DONE after expiry; 1 = reload and restart the same phase
- EXT_STEP, 2, cycles added to cur_delay per accepted extension (used only with the optional feature)
- MAX_EXT, 3, maximum accepted extensions per phase run (used only with the optional feature)

Ports:
- clk  in  1  system clock, rising edge
- reset  in  1  asynchronous, active-low reset
- enable  in  1  run enable; low forces IDLE
- phase  in  PW=$clog2(NUM_PHASES)  current FSM phase index
- delays  in  NUM_PHASES*CNT_W  packed delays; phase i occupies bits [i*CNT_W +: CNT_W]
- ext_req  in  1  extension request, one pulse per request (active only with the optional feature)
- count  out  CNT_W  elapsed-cycle counter
- cur_delay  out  CNT_W  delay latched for the running phase
- phase_onehot  out  NUM_PHASES  one-hot of the latched phase; 0 when IDLE
- expire  out  1  one-cycle pulse: interval elapsed
- busy  out  1  high in RUN

Behaviour:
- Reset (asynchronous, reset=0): state=IDLE; count, cur_delay, phase_onehot, expire and busy all 0; ext counter 0; latched phase 0.
- All outputs are registered.
- States: IDLE, RUN, DONE.
- IDLE:
  - enable=0 keeps the block in IDLE.
  - enable=1 → RUN; on that edge, latch phase, cur_delay=delays[phase], count=0, ext counter 0.
- RUN, each edge:
  - If count==cur_delay: expire=1 for one cycle. Then go to DONE if AUTO_RELOAD=0; otherwise reload cur_delay from delays[phase], count=0, stay in RUN.
  - Otherwise: count+1.
- Latency: with delay D, expire is high during the cycle after the (D+1)th edge following the load edge.
  - D=0 gives expire one edge after the load edge.
  - count never wraps; comparison stops it at cur_delay ≤ 2^CNT_W−1.
- DONE:
  - count holds cur_delay; busy=0; expire=0.
  - A change of phase versus the latched phase reloads from the new phase and goes to RUN.
- Phase change in RUN (phase ≠ latched phase): reload from the new phase, count=0, ext counter 0, no expire. This has priority over expiry on the same edge.
- enable=0 in any state: IDLE next edge, count=0, expire=0. This has priority over everything.
- delays changing mid-run has no effect until the next load.
- Out-of-range phase (≥NUM_PHASES): treated as phase 0.
- phase_onehot = 1<<latched phase in RUN/DONE.
- Reset mid-run: immediate asynchronous return to reset values; no expire.

Optional Feature:
Macro PHASE_TIMER_EXTEND_EN.
- Defined:
  - ext_req=1 in RUN, on an edge with no expiry or phase change, and with ext counter < MAX_EXT: cur_delay = min(cur_delay+EXT_STEP, 2^CNT_W−1), ext counter +1.
  - Requests are ignored in IDLE/DONE, on the expire edge, or once the cap is reached.
- Undefined: ext_req is unused; cur_delay changes only on load; no extension logic is synthesised.

Decomposition:
- Package phase_timer_pkg holds:
  - state enum type (IDLE, RUN, DONE)
  - function clog2_min1
  - function sat_add(a, b, width)
- One natural sub-module, phase_delay_mux: combinational selection of the CNT_W slice for a phase index, with out-of-range mapped to 0.

Test Plan:
- Reset, then enable=1, phase=2, delays={4'd1,4'd3,4'd5,4'd2} (phase3..0) → count runs 0..3; expire high exactly one cycle 4 edges after load; state DONE, busy=0, phase_onehot=4'b0100.
- AUTO_RELOAD=1, phase=0, delay0=0 → expire high every other cycle, count stays 0; the sequence continues until enable=0.
- Phase changes 1→3 while count=2 (delay1=5, delay3=1) → no expire; count=0, cur_delay=1; expire 2 edges later; phase_onehot=4'b1000.
- Phase change on the same edge count==cur_delay → no expire; reload of the new phase. enable=0 on the same edge → IDLE, all outputs 0.
- Extension enabled, delay=4'd13, EXT_STEP=2, MAX_EXT=3, four ext_req pulses → cur_delay 13→15→15→15 (saturation), fourth request ignored by the cap; expire after count reaches 15.
- Assert reset mid-RUN at count=3 → count, cur_delay, phase_onehot, expire and busy go to 0 without waiting for a clock edge; after release with enable=1, a clean reload occurs.
